// File: rtl/lzd_norm_pipe_if.sv
// rtl/lzd_norm_pipe_if.sv - input/output beat bundle for the normalising leading-digit detector
interface lzd_norm_pipe_if #(
  parameter int W    = 32,
  parameter int TAGW = 4
);
  localparam int CW = $clog2(W);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_mode;
  logic [CW-1:0]   in_lim;
  logic [TAGW-1:0] in_tag;

  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_norm;
  logic [CW-1:0]   out_cnt;
  logic            out_none;
  logic            out_clamp;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_lim, in_tag, out_ready,
    input  in_ready, out_valid, out_norm, out_cnt, out_none, out_clamp, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_lim, in_tag, out_ready,
    output in_ready, out_valid, out_norm, out_cnt, out_none, out_clamp, out_tag
  );
endinterface

// File: rtl/lzd_norm_pipe.sv
// rtl/lzd_norm_pipe.sv - 3-stage leading-one/leading-sign detector with clamped normalising shift
module lzd_norm_pipe #(
  parameter int W    = 32,
  parameter int TAGW = 4
) (
  input  logic               clk,
  input  logic               rst,
  lzd_norm_pipe_if.slave     bus
);
  localparam int CW = $clog2(W);

  // Log2(W) levels of 2:1 priority merges; the upper half wins, else the lower
  // half's count is offset by the half width. Result is {none, distance}.
  function automatic logic [CW:0] lzc(input logic [W-1:0] t);
    logic [W-1:0]  v;
    logic [CW-1:0] c [W];
    logic [CW-1:0] c_m;
    logic          v_m;
    v = t;
    for (int i = 0; i < W; i++) c[i] = '0;
    for (int k = 0; k < CW; k++) begin
      for (int g = 0; g < (W >> (k + 1)); g++) begin
        v_m  = v[2*g+1] | v[2*g];
        c_m  = v[2*g+1] ? c[2*g+1] : (c[2*g] | (CW'(1) << k));
        v[g] = v_m;
        c[g] = c_m;
      end
    end
    return {~v[0], (v[0] ? c[0] : '0)};
  endfunction

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  logic [W-1:0] t_in;
  always_comb begin
    t_in = bus.in_data;
    if (bus.in_mode) t_in = {bus.in_data[W-1:1] ^ bus.in_data[W-2:0], 1'b0};
  end

  logic            s1_valid;
  logic [W-1:0]    s1_data;
  logic [W-1:0]    s1_t;
  logic [CW-1:0]   s1_lim;
  logic [TAGW-1:0] s1_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_t     <= '0;
      s1_lim   <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_data  <= bus.in_data;
      s1_t     <= t_in;
      s1_lim   <= bus.in_lim;
      s1_tag   <= bus.in_tag;
    end
  end

  logic [CW:0]   det;
  logic          d_none;
  logic [CW-1:0] d_raw;
  logic          d_clamp;
  logic [CW-1:0] d_cnt;

  always_comb begin
    det     = lzc(s1_t);
    d_none  = det[CW];
    d_raw   = det[CW-1:0];
    d_clamp = !d_none && (d_raw > s1_lim);
    d_cnt   = d_clamp ? s1_lim : d_raw;
  end

  logic            s2_valid;
  logic [W-1:0]    s2_data;
  logic [CW-1:0]   s2_cnt;
  logic            s2_none;
  logic            s2_clamp;
  logic [TAGW-1:0] s2_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_cnt   <= '0;
      s2_none  <= 1'b0;
      s2_clamp <= 1'b0;
      s2_tag   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_data  <= s1_data;
      s2_cnt   <= d_cnt;
      s2_none  <= d_none;
      s2_clamp <= d_clamp;
      s2_tag   <= s1_tag;
    end
  end

  logic            s3_valid;
  logic [W-1:0]    s3_norm;
  logic [CW-1:0]   s3_cnt;
  logic            s3_none;
  logic            s3_clamp;
  logic [TAGW-1:0] s3_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_norm  <= '0;
      s3_cnt   <= '0;
      s3_none  <= 1'b0;
      s3_clamp <= 1'b0;
      s3_tag   <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_norm  <= s2_data << s2_cnt;
      s3_cnt   <= s2_cnt;
      s3_none  <= s2_none;
      s3_clamp <= s2_clamp;
      s3_tag   <= s2_tag;
    end
  end

  assign bus.out_valid = s3_valid;
  assign bus.out_norm  = s3_norm;
  assign bus.out_cnt   = s3_cnt;
  assign bus.out_none  = s3_none;
  assign bus.out_clamp = s3_clamp;
  assign bus.out_tag   = s3_tag;
endmodule
